// File: rtl/bin_to_bcd_pkg.sv
// Shared defaults, FSM state type and counter sizing helper for the binary-to-BCD converter.
package bin_to_bcd_pkg;

    localparam int BIN_W_DEF  = 14;
    localparam int DIGITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Smallest w with 2**w >= n+1, i.e. ceil(log2(n+1)).
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 ahead of the left shift.
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary to packed BCD converter (shift-add-3) with a valid/ready request port.
// Build option BCD_SATURATE_EN: an overflowing value is presented as all nines instead of mod 10^DIGITS.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    // Scratch holds one extra BCD digit above the presented ones to catch overflow.
    localparam int SW = 4 * (DIGITS + 1) + BIN_W;
    localparam int CW = cnt_width(BIN_W);

    state_t                r_state;
    state_t                w_next;
    logic [SW-1:0]         r_scratch;
    logic [SW-1:0]         w_adjusted;
    logic [SW-1:0]         w_shifted;
    logic                  w_unused_msb;
    logic [CW-1:0]         r_cnt;
    logic                  w_last;
    logic [4*DIGITS-1:0]   w_bcd_low;
    logic [4*DIGITS-1:0]   w_bcd_sel;
    logic                  w_ovf;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;

    function automatic logic [4*DIGITS-1:0] sat_bcd(input logic [4*DIGITS-1:0] low, input logic ovf);
`ifdef BCD_SATURATE_EN
        return ovf ? {DIGITS{4'h9}} : low;
`else
        logic unused_ovf;
        unused_ovf = ovf;
        return low;
`endif
    endfunction

    for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[BIN_W + 4*g +: 4]),
            .o_digit (w_adjusted[BIN_W + 4*g +: 4])
        );
    end

    assign w_adjusted[BIN_W-1:0] = r_scratch[BIN_W-1:0];
    assign w_shifted             = {w_adjusted[SW-2:0], 1'b0};
    assign w_unused_msb          = w_adjusted[SW-1];
    assign w_last                = (r_cnt == CW'(BIN_W - 1));

    assign w_bcd_low = w_shifted[BIN_W +: 4*DIGITS];
    assign w_ovf     = |w_shifted[BIN_W + 4*DIGITS +: 4];
    assign w_bcd_sel = sat_bcd(w_bcd_low, w_ovf);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (r_state == IDLE && in_valid) begin
            r_scratch <= {{(4*(DIGITS+1)){1'b0}}, bin};
            r_cnt     <= '0;
        end else if (r_state == SHIFT) begin
            r_scratch <= w_shifted;
            r_cnt     <= r_cnt + CW'(1);
        end
    end

    // Result registers hold their value until the next completed conversion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bcd <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT && w_last) begin
            r_bcd <= w_bcd_sel;
            r_ovf <= w_ovf;
        end
    end

    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomized and directed bench for bin_to_bcd against an arithmetic reference model.
module tb_bin_to_bcd;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int BW     = 4 * DIGITS;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BIN_W-1:0] bin;
    logic          out_valid;
    logic [BW-1:0] bcd;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    typedef struct {
        int          acc;
        logic [BW-1:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t q[$];

    bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .bcd       (bcd),
        .overflow  (overflow)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    function automatic logic [BW-1:0] model_bcd(input int v);
        logic [BW-1:0] r;
        int low;
        int p;
        r   = '0;
        low = v % (10 ** DIGITS);
`ifdef BCD_SATURATE_EN
        if (v >= 10 ** DIGITS) return {DIGITS{4'h9}};
`endif
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((low / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Acceptance monitor: records what each accepted request must produce.
    always @(posedge clock) begin
        exp_t e;
        cyc = cyc + 1;
        if (reset) begin
            q.delete();
        end else if (mon_en && in_valid && in_ready) begin
            e.acc = cyc;
            e.bcd = model_bcd(int'(bin));
            e.ovf = (int'(bin) >= 10 ** DIGITS);
            q.push_back(e);
        end
    end

    // Compare process: handshake and result checked on every cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            logic exp_ov;
            exp_ov = (q.size() != 0) && (cyc - q[0].acc == BIN_W);
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (out_valid && q.size() != 0) begin
                chk("model_bcd", 32'(bcd), 32'(q[0].bcd));
                chk("model_overflow", 32'(overflow), 32'(q[0].ovf));
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_done(output int t);
        int n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!out_valid) chk("done_timeout", 32'(out_valid), 32'd1);
        t = cyc;
    endtask

    task automatic run_one(input string nm, input int v, input logic [BW-1:0] eb, input logic eo);
        int acc;
        int t;
        wait_ready();
        in_valid = 1'b1;
        bin      = BIN_W'(v);
        @(negedge clock);
        in_valid = 1'b0;
        acc      = cyc;
        wait_done(t);
        chk({nm, "_bcd"}, 32'(bcd), 32'(eb));
        chk({nm, "_ovf"}, 32'(overflow), 32'(eo));
        chk({nm, "_latency"}, 32'(t - acc), 32'(BIN_W));
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int pulses;

        reset    = 1'b1;
        in_valid = 1'b0;
        bin      = '0;

        chk("pin_model_1234", 32'(model_bcd(1234)), 32'h1234);
        chk("pin_model_15", 32'(model_bcd(15)), 32'h0015);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_one("sweep", i, BW'(((i / 10) << 4) | (i % 10)), 1'b0);
        end

        run_one("v9999", 9999, 16'h9999, 1'b0);
        run_one("v1234", 1234, 16'h1234, 1'b0);
`ifdef BCD_SATURATE_EN
        run_one("v10000", 10000, 16'h9999, 1'b1);
        run_one("v16383", 16383, 16'h9999, 1'b1);
`else
        run_one("v10000", 10000, 16'h0000, 1'b1);
        run_one("v16383", 16383, 16'h6383, 1'b1);
`endif

        // Request during SHIFT must be dropped.
        wait_ready();
        in_valid = 1'b1;
        bin      = BIN_W'(42);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("busy_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1;
        bin      = BIN_W'(77);
        @(negedge clock);
        in_valid = 1'b0;
        wait_done(t1);
        chk("ignore_bcd", 32'(bcd), 32'h0042);
        chk("done_ready", 32'(in_ready), 32'h0);
        pulses = 0;
        repeat (25) begin
            @(negedge clock);
            if (out_valid) pulses++;
        end
        chk("ignore_pulses", 32'(pulses), 32'h0);

        // Reset 5 cycles into a conversion of 500.
        in_valid = 1'b1;
        bin      = BIN_W'(500);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_bcd", 32'(bcd), 32'h0);
        chk("abort_ovf", 32'(overflow), 32'h0);
        chk("abort_ready", 32'(in_ready), 32'h1);
        pulses = 0;
        repeat (25) begin
            @(negedge clock);
            if (out_valid) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'h0);

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        bin      = BIN_W'(7);
        @(negedge clock);
        wait_done(t1);
        chk("b2b_first", 32'(bcd), 32'h0007);
        bin = BIN_W'(8);
        @(negedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        wait_done(t2);
        chk("b2b_second", 32'(bcd), 32'h0008);
        chk("b2b_spacing", 32'(t2 - t1), 32'(BIN_W + 2));
        @(negedge clock);

        // Randomized traffic, including requests while busy and range corners.
        repeat (1500) begin
            @(negedge clock);
            in_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0: bin = BIN_W'(0);
                1: bin = BIN_W'(9999);
                2: bin = BIN_W'(10000);
                3: bin = BIN_W'(16383);
                default: bin = BIN_W'($urandom_range(0, 16383));
            endcase
        end
        in_valid = 1'b0;
        repeat (40) @(negedge clock);
        chk("drain_queue", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
